wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the writeback data width.
REQ-002 Parameter REG_N, default 32, SHALL set the architectural register count; register-number width RW = log2(REG_N) = 5.
REQ-003 i_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rstn  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 i_issue_valid / o_issue_ready / i_issue_rd  in/out/in  1/1/RW  SHALL form the issue port: an instruction reserves destination rd.
REQ-006 i_lsu_valid / o_lsu_ready / i_lsu_rd / i_lsu_data  in/out/in/in  1/1/RW/DATA_W  SHALL form the load-result writeback source.
REQ-007 i_alu_valid / o_alu_ready / i_alu_rd / i_alu_data  in/out/in/in  1/1/RW/DATA_W  SHALL form the ALU-result writeback source.
REQ-008 o_Wen / o_Wnum / o_Wd  out  1/RW/DATA_W  SHALL drive the register-file write port; all three are registered.
REQ-009 i_rs1 / i_rs2  in  RW  SHALL be the register numbers queried by decode.
REQ-010 o_rs1_busy / o_rs2_busy  out  1  SHALL flag a queried register with an outstanding reservation.
REQ-011 o_rs1_fwd / o_rs2_fwd  out  1, and o_rs1_fwd_data / o_rs2_fwd_data  out  DATA_W  SHALL bypass the value currently on the write port.
REQ-012 o_wb_err  out  1  SHALL be a sticky flag for a writeback to an unreserved nonzero register.

Function
REQ-013 A transfer on any port SHALL occur at a rising edge where valid and ready are both high.
REQ-014 Internal state SHALL be a REG_N-bit pending vector, a 1-bit last_loser flag (0 = LSU, 1 = ALU), and the write-port registers.
REQ-015 pending[0] SHALL be constant 0; x0 is never reserved, busy or forwarded.
REQ-016 o_issue_ready SHALL be combinational: !pending[i_issue_rd]; issue with rd = 0 is always ready and has no effect.
REQ-017 Arbitration: if only one source is valid it SHALL win; if both are valid, the ALU wins when last_loser = 1, else the LSU wins.
REQ-018 o_lsu_ready / o_alu_ready SHALL be high exactly for the winner; with no valid input both are high.
REQ-019 When both sources are valid, last_loser SHALL update to the loser; otherwise it SHALL hold.
REQ-020 An accepted writeback at edge N SHALL give o_Wen = 1, o_Wnum = rd, o_Wd = data for cycle N+1 (latency 1); o_Wen = 0 in cycles with no acceptance.
REQ-021 An accepted writeback with rd = 0 SHALL be consumed with o_Wen = 0 and no pending change.
REQ-022 An accepted writeback SHALL clear pending[rd] at edge N; if that bit was already 0 and rd != 0, o_wb_err SHALL set and the write SHALL still proceed.
REQ-023 An accepted issue SHALL set pending[i_issue_rd] at the same edge; a set and a clear of different registers in one cycle SHALL both take effect.
REQ-024 Issue to rd X and writeback to X in one cycle: the issue is not ready (pending[X] = 1 before the edge), so the clear alone applies.
REQ-025 o_rsK_busy SHALL equal pending[i_rsK] combinationally (K = 1, 2).
REQ-026 o_rsK_fwd SHALL be o_Wen & (o_Wnum == i_rsK) & (i_rsK != 0), with o_rsK_fwd_data = o_Wd; fwd_data SHALL be 0 when fwd is low.

Reset
REQ-027 On i_rstn low, immediately and independent of i_clk: pending = 0, last_loser = 0, o_Wen = 0, o_Wnum = 0, o_Wd = 0, o_wb_err = 0.
REQ-028 Reset asserted mid-operation SHALL discard any write in flight; no o_Wen pulse SHALL follow deassertion without a new acceptance.
REQ-029 o_wb_err SHALL clear only on reset.

Verification
REQ-030 Issue rd = 5, then ALU writeback rd = 5, data 0xDEADBEEF -> o_rs1_busy (i_rs1 = 5) high until the accept edge; next cycle o_Wen = 1, o_Wnum = 5, o_Wd = 0xDEADBEEF, o_rs1_fwd = 1.
REQ-031 LSU and ALU both valid for 4 cycles, last_loser = 0 after reset -> winners LSU, ALU, LSU, ALU.
REQ-032 Issue rd = 7 twice back-to-back -> second issue sees o_issue_ready = 0 until the rd = 7 writeback is accepted.
REQ-033 ALU writeback rd = 0, data 0x1234 -> o_alu_ready = 1, o_Wen stays 0, o_wb_err stays 0.
REQ-034 Writeback to unreserved rd = 9 -> o_wb_err = 1 and the write to x9 is still performed; pulse i_rstn low -> all outputs 0.
REQ-035 Assert i_rstn low one cycle after an accepted writeback -> o_Wen drops asynchronously, and pending and last_loser read 0.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: issue port, two writeback sources, register-file
// write port and decode busy/forward queries.
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
);
  localparam int RW = $clog2(REG_N);

  logic              i_issue_valid;
  logic              o_issue_ready;
  logic [RW-1:0]     i_issue_rd;

  logic              i_lsu_valid;
  logic              o_lsu_ready;
  logic [RW-1:0]     i_lsu_rd;
  logic [DATA_W-1:0] i_lsu_data;

  logic              i_alu_valid;
  logic              o_alu_ready;
  logic [RW-1:0]     i_alu_rd;
  logic [DATA_W-1:0] i_alu_data;

  logic              o_Wen;
  logic [RW-1:0]     o_Wnum;
  logic [DATA_W-1:0] o_Wd;

  logic [RW-1:0]     i_rs1;
  logic [RW-1:0]     i_rs2;
  logic              o_rs1_busy;
  logic              o_rs2_busy;
  logic              o_rs1_fwd;
  logic              o_rs2_fwd;
  logic [DATA_W-1:0] o_rs1_fwd_data;
  logic [DATA_W-1:0] o_rs2_fwd_data;

  logic              o_wb_err;

  modport slave (
    input  i_issue_valid, i_issue_rd,
    input  i_lsu_valid, i_lsu_rd, i_lsu_data,
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_rs1, i_rs2,
    output o_issue_ready, o_lsu_ready, o_alu_ready,
    output o_Wen, o_Wnum, o_Wd,
    output o_rs1_busy, o_rs2_busy, o_rs1_fwd, o_rs2_fwd,
    output o_rs1_fwd_data, o_rs2_fwd_data,
    output o_wb_err
  );

  modport master (
    output i_issue_valid, i_issue_rd,
    output i_lsu_valid, i_lsu_rd, i_lsu_data,
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_rs1, i_rs2,
    input  o_issue_ready, o_lsu_ready, o_alu_ready,
    input  o_Wen, o_Wnum, o_Wd,
    input  o_rs1_busy, o_rs2_busy, o_rs1_fwd, o_rs2_fwd,
    input  o_rs1_fwd_data, o_rs2_fwd_data,
    input  o_wb_err
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin between LSU and ALU results onto a single
// registered register-file write port, with a pending-reservation scoreboard.
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  wb_arbiter_if.slave  bus
);
  localparam int RW = $clog2(REG_N);

  logic [REG_N-1:0]  pending_q, pending_d;
  logic              last_loser_q, last_loser_d;
  logic              wen_q, wen_d;
  logic [RW-1:0]     wnum_q, wnum_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              err_q, err_d;

  logic              lsu_win, alu_win, wb_fire, issue_fire;
  logic [RW-1:0]     wb_rd;
  logic [DATA_W-1:0] wb_data;

  always_comb begin
    // last_loser = 1 means the ALU lost the previous contested cycle.
    lsu_win    = bus.i_lsu_valid & (~bus.i_alu_valid | ~last_loser_q);
    alu_win    = bus.i_alu_valid & (~bus.i_lsu_valid |  last_loser_q);
    wb_fire    = lsu_win | alu_win;
    wb_rd      = lsu_win ? bus.i_lsu_rd   : bus.i_alu_rd;
    wb_data    = lsu_win ? bus.i_lsu_data : bus.i_alu_data;
    issue_fire = bus.i_issue_valid & ~pending_q[bus.i_issue_rd] & (bus.i_issue_rd != '0);

    pending_d = pending_q;
    if (wb_fire)    pending_d[wb_rd]          = 1'b0;
    if (issue_fire) pending_d[bus.i_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;

    err_d = err_q | (wb_fire & (wb_rd != '0) & ~pending_q[wb_rd]);

    last_loser_d = (bus.i_lsu_valid & bus.i_alu_valid) ? lsu_win : last_loser_q;

    wen_d  = wb_fire & (wb_rd != '0);
    wnum_d = wen_d ? wb_rd   : wnum_q;
    wd_d   = wen_d ? wb_data : wd_q;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pending_q    <= '0;
      last_loser_q <= 1'b0;
      wen_q        <= 1'b0;
      wnum_q       <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      last_loser_q <= last_loser_d;
      wen_q        <= wen_d;
      wnum_q       <= wnum_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
    end
  end

  logic rs1_fwd, rs2_fwd;
  assign rs1_fwd = wen_q & (wnum_q == bus.i_rs1) & (bus.i_rs1 != '0);
  assign rs2_fwd = wen_q & (wnum_q == bus.i_rs2) & (bus.i_rs2 != '0);

  assign bus.o_issue_ready  = ~pending_q[bus.i_issue_rd];
  assign bus.o_lsu_ready    = ~alu_win;
  assign bus.o_alu_ready    = ~lsu_win;
  assign bus.o_Wen          = wen_q;
  assign bus.o_Wnum         = wnum_q;
  assign bus.o_Wd           = wd_q;
  assign bus.o_rs1_busy     = pending_q[bus.i_rs1];
  assign bus.o_rs2_busy     = pending_q[bus.i_rs2];
  assign bus.o_rs1_fwd      = rs1_fwd;
  assign bus.o_rs2_fwd      = rs2_fwd;
  assign bus.o_rs1_fwd_data = rs1_fwd ? wd_q : '0;
  assign bus.o_rs2_fwd_data = rs2_fwd ? wd_q : '0;
  assign bus.o_wb_err       = err_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table with a writeback
// scoreboard, followed by reset corner-case sequences.
module tb_wb_arbiter;
  logic clk;
  logic rstn;

  wb_arbiter_if #(.DATA_W(32), .REG_N(32)) bus ();

  wb_arbiter #(.DATA_W(32), .REG_N(32)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;  logic [4:0] ird;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic [4:0]  rs1; logic [4:0] rs2;
    logic        e_ir, e_lr, e_ar, e_b1, e_b2;
    logic        e_f1; logic [31:0] e_fd1;
    logic        e_f2; logic [31:0] e_fd2;
    logic        e_wen; logic [4:0] e_wnum; logic [31:0] e_wd; logic e_err;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [4:0]  wnum;
    logic [31:0] wd;
    logic        err;
  } exp_wb_t;

  int checks   = 0;
  int failures = 0;
  exp_wb_t sb[$];
  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input int iv, ird, lv, lrd, input logic [31:0] ld,
    input int av, ard, input logic [31:0] ad, input int rs1, rs2,
    input int e_ir, e_lr, e_ar, e_b1, e_b2,
    input int e_f1, input logic [31:0] e_fd1, input int e_f2, input logic [31:0] e_fd2,
    input int e_wen, e_wnum, input logic [31:0] e_wd, input int e_err);
    vec_t v;
    v.iv = 1'(iv);   v.ird = 5'(ird);
    v.lv = 1'(lv);   v.lrd = 5'(lrd);  v.ld = ld;
    v.av = 1'(av);   v.ard = 5'(ard);  v.ad = ad;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.e_ir = 1'(e_ir); v.e_lr = 1'(e_lr); v.e_ar = 1'(e_ar);
    v.e_b1 = 1'(e_b1); v.e_b2 = 1'(e_b2);
    v.e_f1 = 1'(e_f1); v.e_fd1 = e_fd1; v.e_f2 = 1'(e_f2); v.e_fd2 = e_fd2;
    v.e_wen = 1'(e_wen); v.e_wnum = 5'(e_wnum); v.e_wd = e_wd; v.e_err = 1'(e_err);
    return v;
  endfunction

  task automatic drive_idle();
    bus.i_issue_valid = 1'b0; bus.i_issue_rd = '0;
    bus.i_lsu_valid = 1'b0; bus.i_lsu_rd = '0; bus.i_lsu_data = '0;
    bus.i_alu_valid = 1'b0; bus.i_alu_rd = '0; bus.i_alu_data = '0;
    bus.i_rs1 = '0; bus.i_rs2 = '0;
  endtask

  task automatic apply_row(input vec_t v, input int idx);
    exp_wb_t e, got;
    bus.i_issue_valid = v.iv; bus.i_issue_rd = v.ird;
    bus.i_lsu_valid = v.lv; bus.i_lsu_rd = v.lrd; bus.i_lsu_data = v.ld;
    bus.i_alu_valid = v.av; bus.i_alu_rd = v.ard; bus.i_alu_data = v.ad;
    bus.i_rs1 = v.rs1; bus.i_rs2 = v.rs2;
    e.wen = v.e_wen; e.wnum = v.e_wnum; e.wd = v.e_wd; e.err = v.e_err;
    sb.push_back(e);
    @(negedge clk);
    chk($sformatf("r%0d issue_ready", idx), 32'(bus.o_issue_ready), 32'(v.e_ir));
    chk($sformatf("r%0d lsu_ready", idx), 32'(bus.o_lsu_ready), 32'(v.e_lr));
    chk($sformatf("r%0d alu_ready", idx), 32'(bus.o_alu_ready), 32'(v.e_ar));
    chk($sformatf("r%0d rs1_busy", idx), 32'(bus.o_rs1_busy), 32'(v.e_b1));
    chk($sformatf("r%0d rs2_busy", idx), 32'(bus.o_rs2_busy), 32'(v.e_b2));
    chk($sformatf("r%0d rs1_fwd", idx), 32'(bus.o_rs1_fwd), 32'(v.e_f1));
    chk($sformatf("r%0d rs1_fwd_data", idx), bus.o_rs1_fwd_data, v.e_fd1);
    chk($sformatf("r%0d rs2_fwd", idx), 32'(bus.o_rs2_fwd), 32'(v.e_f2));
    chk($sformatf("r%0d rs2_fwd_data", idx), bus.o_rs2_fwd_data, v.e_fd2);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk($sformatf("r%0d Wen", idx), 32'(bus.o_Wen), 32'(got.wen));
    if (got.wen) begin
      chk($sformatf("r%0d Wnum", idx), 32'(bus.o_Wnum), 32'(got.wnum));
      chk($sformatf("r%0d Wd", idx), bus.o_Wd, got.wd);
    end
    chk($sformatf("r%0d wb_err", idx), 32'(bus.o_wb_err), 32'(got.err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        iv ird lv lrd ld          av ard ad            rs1 rs2 ir lr ar b1 b2 f1 fd1           f2 fd2          wen wnum wd          err
    vecs[0]  = mk(1,5, 0,0,0,          0,0,0,              5,7, 1,1,1,0,0, 0,0,            0,0,           0,0,0,            0);
    vecs[1]  = mk(1,7, 0,0,0,          0,0,0,              5,7, 1,1,1,1,0, 0,0,            0,0,           0,0,0,            0);
    vecs[2]  = mk(1,7, 0,0,0,          1,5,32'hDEADBEEF,   5,7, 0,0,1,1,1, 0,0,            0,0,           1,5,32'hDEADBEEF, 0);
    vecs[3]  = mk(1,7, 0,0,0,          0,0,0,              5,7, 0,1,1,0,1, 1,32'hDEADBEEF, 0,0,           0,0,0,            0);
    vecs[4]  = mk(1,7, 1,7,32'h77,     0,0,0,              7,5, 0,1,0,1,0, 0,0,            0,0,           1,7,32'h77,       0);
    vecs[5]  = mk(1,7, 0,0,0,          0,0,0,              7,0, 1,1,1,0,0, 1,32'h77,       0,0,           0,0,0,            0);
    vecs[6]  = mk(1,3, 0,0,0,          0,0,0,              3,7, 1,1,1,0,1, 0,0,            0,0,           0,0,0,            0);
    vecs[7]  = mk(1,4, 0,0,0,          0,0,0,              3,4, 1,1,1,1,0, 0,0,            0,0,           0,0,0,            0);
    vecs[8]  = mk(1,6, 0,0,0,          0,0,0,              4,6, 1,1,1,1,0, 0,0,            0,0,           0,0,0,            0);
    vecs[9]  = mk(0,0, 1,3,32'h33,     1,4,32'h44,         3,4, 1,1,0,1,1, 0,0,            0,0,           1,3,32'h33,       0);
    vecs[10] = mk(0,0, 1,6,32'h66,     1,4,32'h44,         3,4, 1,0,1,0,1, 1,32'h33,       0,0,           1,4,32'h44,       0);
    vecs[11] = mk(0,0, 1,6,32'h66,     1,7,32'h71,         4,6, 1,1,0,0,1, 1,32'h44,       0,0,           1,6,32'h66,       0);
    vecs[12] = mk(0,0, 1,0,32'h5,      1,7,32'h71,         6,7, 1,0,1,0,1, 1,32'h66,       0,0,           1,7,32'h71,       0);
    vecs[13] = mk(0,0, 0,0,0,          1,0,32'h1234,       7,7, 1,0,1,0,0, 1,32'h71,       1,32'h71,      0,0,0,            0);
    vecs[14] = mk(0,0, 0,0,0,          0,0,0,              0,0, 1,1,1,0,0, 0,0,            0,0,           0,0,0,            0);
    vecs[15] = mk(0,0, 0,0,0,          1,9,32'h99,         9,0, 1,0,1,0,0, 0,0,            0,0,           1,9,32'h99,       1);
    vecs[16] = mk(0,0, 0,0,0,          0,0,0,              9,9, 1,1,1,0,0, 1,32'h99,       1,32'h99,      0,0,0,            1);

    drive_idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset Wen", 32'(bus.o_Wen), 32'd0);
    chk("reset Wnum", 32'(bus.o_Wnum), 32'd0);
    chk("reset Wd", bus.o_Wd, 32'd0);
    chk("reset wb_err", 32'(bus.o_wb_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) apply_row(vecs[i], i);

    // Reset pulse clears the sticky error and the write port.
    rstn = 1'b0;
    #1;
    chk("pulse Wen", 32'(bus.o_Wen), 32'd0);
    chk("pulse Wnum", 32'(bus.o_Wnum), 32'd0);
    chk("pulse Wd", bus.o_Wd, 32'd0);
    chk("pulse wb_err", 32'(bus.o_wb_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Contested rd=0 writebacks move last_loser to ALU, and reserve x11.
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd11;
    bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = '0; bus.i_lsu_data = 32'h1;
    bus.i_alu_valid = 1'b1; bus.i_alu_rd = '0; bus.i_alu_data = 32'h2;
    @(negedge clk);
    chk("s1 lsu_ready", 32'(bus.o_lsu_ready), 32'd1);
    chk("s1 alu_ready", 32'(bus.o_alu_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("s1 Wen", 32'(bus.o_Wen), 32'd0);

    bus.i_issue_rd = 5'd12;
    bus.i_lsu_rd = 5'd11; bus.i_lsu_data = 32'hAA;
    bus.i_alu_valid = 1'b0;
    bus.i_rs1 = 5'd11;
    @(negedge clk);
    chk("s2 rs1_busy", 32'(bus.o_rs1_busy), 32'd1);
    @(posedge clk);
    #1;
    chk("s2 Wen", 32'(bus.o_Wen), 32'd1);
    chk("s2 Wnum", 32'(bus.o_Wnum), 32'd11);
    chk("s2 Wd", bus.o_Wd, 32'hAA);

    bus.i_issue_valid = 1'b0;
    bus.i_lsu_rd = '0; bus.i_alu_valid = 1'b1; bus.i_alu_rd = '0;
    bus.i_rs1 = 5'd12;
    #1;
    chk("pre-rst rs1_busy", 32'(bus.o_rs1_busy), 32'd1);
    chk("pre-rst alu_ready", 32'(bus.o_alu_ready), 32'd1);
    rstn = 1'b0;
    #1;
    chk("async Wen", 32'(bus.o_Wen), 32'd0);
    chk("async Wnum", 32'(bus.o_Wnum), 32'd0);
    chk("async Wd", bus.o_Wd, 32'd0);
    chk("async rs1_busy", 32'(bus.o_rs1_busy), 32'd0);
    chk("async lsu_ready", 32'(bus.o_lsu_ready), 32'd1);
    chk("async alu_ready", 32'(bus.o_alu_ready), 32'd0);
    drive_idle();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst Wen", 32'(bus.o_Wen), 32'd0);
    @(posedge clk);
    #1;
    chk("post-rst Wen2", 32'(bus.o_Wen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
